uart_frame_sequencer: RTL and testbench
=======================================

# uart_frame_sequencer

- Builds a fixed-format telemetry frame from a 16-bit temperature word and a 16-bit auxiliary word.
- Feeds the frame byte by byte into the existing async byte transmitter through its start/busy handshake.
- Sits between the 1-wire sensor controller and the UART transmitter on the 10 MHz board clock.
- Replaces ad-hoc per-byte sequencing in the top level with a busy-aware, buffered framer.

## Interface

Parameters:
- SYNC0, default 8'h61 ("a"): first frame byte.
- SYNC1, default 8'h62 ("b"): second frame byte.
- CHECKSUM_EN, default 1: 1 inserts an 8-bit checksum byte before the terminator; 0 omits it.

Ports:
- clk  input  1  system clock (10 MHz board clock).
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
- sample_valid  input  1  one-cycle strobe: temperature/aux words valid this cycle.
- temperature  input  16  sensor temperature word.
- aux_data  input  16  auxiliary/raw word.
- overrun_clr  input  1  synchronous clear of the overrun flag.
- tx_busy  input  1  transmitter busy (high while shifting a byte).
- tx_start  output  1  one-cycle request to the transmitter.
- tx_data  output  8  byte to transmit; stable from tx_start until the next tx_start.
- frame_busy  output  1  high while a frame is in progress.
- frame_done  output  1  one-cycle pulse after the last byte of a frame completes.
- overrun  output  1  sticky: a pending sample was overwritten.
- frame_count  output  16  frames completed, wraps 16'hFFFF -> 0.

## Operation

- Frame byte order: SYNC0, SYNC1, T[7:0], T[15:8], A[7:0], A[15:8], [CSUM], 8'h0D, 8'h0A.
  - Length is 9 bytes with CHECKSUM_EN=1, 8 bytes otherwise.
  - CSUM = (T[7:0] + T[15:8] + A[7:0] + A[15:8]) mod 256. Carries are discarded; SYNC and terminator bytes are excluded.
- Active register: holds T and A for the current frame; captured at frame start and unaffected by later inputs.
- Pending buffer: one entry.
  - sample_valid while frame_busy: if pending is empty, store the sample.
  - If pending is already full: overwrite it and set overrun.
- States:
  - IDLE: sample_valid -> capture into active, go to SEND with byte index 0.
  - SEND: if tx_busy==0, register tx_start=1 and tx_data=byte[idx], go to HOLD. Otherwise remain in SEND.
  - HOLD: exactly one cycle, tx_busy ignored (covers the transmitter's one-cycle busy latency), go to WAIT.
  - WAIT: on tx_busy==0:
    - if idx is the last byte, go to DONE;
    - otherwise idx+1 and go to SEND.
  - DONE: one cycle. Pulse frame_done and increment frame_count.
    - If pending is valid: move pending to active, go to SEND idx 0. A sample_valid on this same edge goes into the freed pending slot, with no overrun.
    - Else if sample_valid: capture into active, go to SEND.
    - Else go to IDLE.
- frame_busy = (state != IDLE).
- overrun: set on an overwrite; cleared by overrun_clr or reset. Set wins if both occur on the same edge.

## Timing

Reset values:
- tx_start=0, tx_data=8'h00, frame_busy=0, frame_done=0, overrun=0, frame_count=0.
- State IDLE, pending empty.

Reset behaviour:
- Reset mid-frame aborts the frame immediately.
- A byte already accepted by the transmitter finishes on its own.
- After release, the first tx_start waits for tx_busy==0.

Cycle-level timing:
- sample_valid is sampled high at edge k with the block in IDLE and tx_busy low:
  - tx_start is high between edges k+1 and k+2;
  - tx_data=SYNC0 from edge k+1 onward.
- tx_start is never high on two consecutive cycles. It is never asserted while tx_busy is high.
- Inter-byte gap: SEND is taken on the first cycle after WAIT sees tx_busy low. This adds 2 cycles of block overhead per byte beyond the transmitter's busy time.
- frame_done is high for one cycle, 1 cycle after the final WAIT exit.
- frame_count updates on the same edge that frame_done rises.
- Back-to-back frame from pending: the new SYNC0 tx_start comes 1 cycle after frame_done.

## Test plan

- Basic frame: T=16'h0191, A=16'h1234, CHECKSUM_EN=1, transmitter model with 5-cycle busy.
  - Required bytes: 61 62 91 01 34 12 D8 0D 0A.
  - One frame_done pulse; frame_count=1.
- CHECKSUM_EN=0, same stimulus: 8 bytes with no D8; tx_start count = 8.
- Pending and overrun:
  - Three sample_valid strobes in one frame (samples S1, S2, S3): S3 overwrites S2 and overrun=1.
  - Second frame carries S3's words.
  - overrun_clr -> overrun=0.
- Handshake stress: tx_busy held high 100 cycles at frame start.
  - tx_start stays 0 until busy drops.
  - No tx_start while busy; tx_start is never asserted on consecutive cycles.
- Reset mid-frame: rst_n low after byte 3.
  - All outputs return to reset values asynchronously.
  - A fresh sample afterwards produces a full frame starting with 61.
- Wrap and simultaneity:
  - Preload frame_count=16'hFFFF via 65535 frames (or force); the next frame_done -> 0.
  - sample_valid on the DONE edge with pending empty starts the next frame with no overrun.

Source files
------------

// File: rtl/uart_frame_sequencer.sv
// Purpose : frames a 16-bit temperature word and a 16-bit aux word as
//           SYNC0 SYNC1 Tlo Thi Alo Ahi [CSUM] 0D 0A and feeds the bytes to a
//           byte transmitter over its tx_start/tx_busy handshake.
// Latency : sample_valid at edge k (idle, tx_busy low) -> tx_start high k+1..k+2.
// Backpres: waits in SEND while tx_busy is high; one pending sample is buffered
//           during a frame, and a further sample overwrites it and sets overrun.
// Ports   : clk/rst_n (async active-low); sample_valid/temperature/aux_data
//           sample input; overrun_clr clears the sticky overrun flag;
//           tx_busy/tx_start/tx_data transmitter handshake; frame_busy,
//           frame_done, overrun, frame_count status.
module uart_frame_sequencer #(
  parameter logic [7:0] SYNC0       = 8'h61,
  parameter logic [7:0] SYNC1       = 8'h62,
  parameter bit         CHECKSUM_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_valid,
  input  logic [15:0] temperature,
  input  logic [15:0] aux_data,
  input  logic        overrun_clr,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        frame_busy,
  output logic        frame_done,
  output logic        overrun,
  output logic [15:0] frame_count
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SEND = 3'd1;
  localparam logic [2:0] ST_HOLD = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Index of the final byte (0x0A): 9-byte frame with checksum, 8 without.
  localparam logic [3:0] LAST_IDX = CHECKSUM_EN ? 4'd8 : 4'd7;

  logic [2:0]  r_state;
  logic [3:0]  r_idx;
  logic [15:0] r_act_t;
  logic [15:0] r_act_a;
  logic        r_pend_vld;
  logic [15:0] r_pend_t;
  logic [15:0] r_pend_a;
  logic        r_tx_start;
  logic [7:0]  r_tx_data;
  logic        r_frame_done;
  logic        r_overrun;
  logic [15:0] r_frame_count;

  logic [7:0]  w_csum;
  logic [7:0]  w_byte;
  logic        w_in_frame;
  logic        w_pend_wr;
  logic        w_overwrite;

  // Modulo-256 sum of the four payload bytes; carries drop out of the 8-bit result.
  assign w_csum = r_act_t[7:0] + r_act_t[15:8] + r_act_a[7:0] + r_act_a[15:8];

  always_comb begin
    w_byte = 8'h0A;
    case (r_idx)
      4'd0:    w_byte = SYNC0;
      4'd1:    w_byte = SYNC1;
      4'd2:    w_byte = r_act_t[7:0];
      4'd3:    w_byte = r_act_t[15:8];
      4'd4:    w_byte = r_act_a[7:0];
      4'd5:    w_byte = r_act_a[15:8];
      4'd6:    w_byte = CHECKSUM_EN ? w_csum : 8'h0D;
      4'd7:    w_byte = CHECKSUM_EN ? 8'h0D : 8'h0A;
      default: w_byte = 8'h0A;
    endcase
  end

  // DONE is excluded from w_in_frame: there the pending slot is either being
  // drained into the active register (so a new sample refills it cleanly) or
  // empty (so a new sample goes straight to the active register).
  assign w_in_frame  = (r_state == ST_SEND) || (r_state == ST_HOLD) || (r_state == ST_WAIT);
  assign w_pend_wr   = sample_valid && (w_in_frame || ((r_state == ST_DONE) && r_pend_vld));
  assign w_overwrite = sample_valid && w_in_frame && r_pend_vld;

  // Frame FSM and transmitter handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_idx         <= 4'd0;
      r_act_t       <= 16'h0000;
      r_act_a       <= 16'h0000;
      r_tx_start    <= 1'b0;
      r_tx_data     <= 8'h00;
      r_frame_done  <= 1'b0;
      r_frame_count <= 16'h0000;
    end else begin
      r_tx_start   <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (sample_valid) begin
            r_act_t <= temperature;
            r_act_a <= aux_data;
            r_idx   <= 4'd0;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!tx_busy) begin
            r_tx_start <= 1'b1;
            r_tx_data  <= w_byte;
            r_state    <= ST_HOLD;
          end
        end
        // The transmitter raises busy one cycle after tx_start; skip that cycle.
        ST_HOLD: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (!tx_busy) begin
            if (r_idx == LAST_IDX) begin
              r_state <= ST_DONE;
            end else begin
              r_idx   <= r_idx + 4'd1;
              r_state <= ST_SEND;
            end
          end
        end
        ST_DONE: begin
          r_frame_done  <= 1'b1;
          r_frame_count <= r_frame_count + 16'd1;
          r_idx         <= 4'd0;
          if (r_pend_vld) begin
            r_act_t <= r_pend_t;
            r_act_a <= r_pend_a;
            r_state <= ST_SEND;
          end else if (sample_valid) begin
            r_act_t <= temperature;
            r_act_a <= aux_data;
            r_state <= ST_SEND;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // One-entry pending buffer and sticky overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_vld <= 1'b0;
      r_pend_t   <= 16'h0000;
      r_pend_a   <= 16'h0000;
      r_overrun  <= 1'b0;
    end else begin
      if (w_pend_wr) begin
        r_pend_vld <= 1'b1;
        r_pend_t   <= temperature;
        r_pend_a   <= aux_data;
      end else if ((r_state == ST_DONE) && r_pend_vld) begin
        r_pend_vld <= 1'b0;
      end
      // Setting takes priority over a same-edge clear.
      if (w_overwrite) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign frame_busy  = (r_state != ST_IDLE);
  assign frame_done  = r_frame_done;
  assign overrun     = r_overrun;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Purpose : self-checking bench for uart_frame_sequencer, one instance with
//           checksum and one without, each driving a 5-cycle-busy transmitter model.
// Latency : expected bytes are queued when a sample is driven, popped on tx_start.
// Backpres: transmitter model busy for 5 cycles, plus a forced-busy window.
module tb_uart_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sample_valid = 1'b0;
  logic        sample_valid_nc = 1'b0;
  logic [15:0] temperature = 16'h0000;
  logic [15:0] aux_data = 16'h0000;
  logic        overrun_clr = 1'b0;
  logic        force_busy = 1'b0;

  logic        tx_busy, tx_start, frame_busy, frame_done, overrun;
  logic [7:0]  tx_data;
  logic [15:0] frame_count;
  logic        tx_busy_nc, tx_start_nc, frame_busy_nc, frame_done_nc, overrun_nc;
  logic [7:0]  tx_data_nc;
  logic [15:0] frame_count_nc;

  int n_checks = 0;
  int n_fail = 0;
  int n_start = 0;
  int n_start_nc = 0;
  int n_done = 0;
  int n0, d0;

  logic [7:0] q[$];
  logic [7:0] q_nc[$];

  always #5 clk = ~clk;

  uart_frame_sequencer #(.CHECKSUM_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
    .temperature(temperature), .aux_data(aux_data), .overrun_clr(overrun_clr),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .frame_busy(frame_busy), .frame_done(frame_done), .overrun(overrun),
    .frame_count(frame_count)
  );

  uart_frame_sequencer #(.CHECKSUM_EN(1'b0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid_nc),
    .temperature(temperature), .aux_data(aux_data), .overrun_clr(overrun_clr),
    .tx_busy(tx_busy_nc), .tx_start(tx_start_nc), .tx_data(tx_data_nc),
    .frame_busy(frame_busy_nc), .frame_done(frame_done_nc), .overrun(overrun_nc),
    .frame_count(frame_count_nc)
  );

  // Transmitter models: busy rises the cycle after tx_start, lasts 5 cycles,
  // and are not reset by rst_n, so an accepted byte always completes.
  int busy_cnt = 0;
  int busy_cnt_nc = 0;
  always @(posedge clk) begin
    if (tx_start) busy_cnt <= 5;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    if (tx_start_nc) busy_cnt_nc <= 5;
    else if (busy_cnt_nc != 0) busy_cnt_nc <= busy_cnt_nc - 1;
  end
  assign tx_busy    = (busy_cnt != 0) || force_busy;
  assign tx_busy_nc = (busy_cnt_nc != 0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Output monitor / scoreboard, sampled on the falling edge.
  logic       prev_start = 1'b0, prev_done = 1'b0, prev_start_nc = 1'b0;
  logic [7:0] e;
  always @(negedge clk) begin
    if (tx_start) begin
      check("start_while_busy", {31'd0, tx_busy}, 32'd0);
      check("start_back2back", {31'd0, prev_start}, 32'd0);
      if (q.size() == 0) check("unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
      else begin
        e = q.pop_front();
        check("byte", {24'd0, tx_data}, {24'd0, e});
      end
      n_start++;
    end
    if (tx_start_nc) begin
      check("nc_start_while_busy", {31'd0, tx_busy_nc}, 32'd0);
      check("nc_start_back2back", {31'd0, prev_start_nc}, 32'd0);
      if (q_nc.size() == 0) check("nc_unexpected_byte", {24'd0, tx_data_nc}, 32'hFFFF_FFFF);
      else begin
        e = q_nc.pop_front();
        check("nc_byte", {24'd0, tx_data_nc}, {24'd0, e});
      end
      n_start_nc++;
    end
    if (frame_done) begin
      check("done_back2back", {31'd0, prev_done}, 32'd0);
      n_done++;
    end
    prev_start    = tx_start;
    prev_start_nc = tx_start_nc;
    prev_done     = frame_done;
  end

  task tick;
    @(negedge clk);
    #1;
  endtask

  task automatic push_frame(input bit csum_en, input logic [15:0] t, input logic [15:0] a);
    logic [7:0] fr[$];
    logic [7:0] cs;
    cs = t[7:0] + t[15:8] + a[7:0] + a[15:8];
    fr = '{8'h61, 8'h62, t[7:0], t[15:8], a[7:0], a[15:8]};
    if (csum_en) fr.push_back(cs);
    fr.push_back(8'h0D);
    fr.push_back(8'h0A);
    foreach (fr[i]) begin
      if (csum_en) q.push_back(fr[i]);
      else q_nc.push_back(fr[i]);
    end
  endtask

  task automatic send(input logic [15:0] t, input logic [15:0] a);
    sample_valid = 1'b1;
    temperature  = t;
    aux_data     = a;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_starts(input int target);
    for (int i = 0; i < 3000; i++) begin
      if (n_start >= target) return;
      tick();
    end
    check("timeout_starts", n_start, target);
  endtask

  task automatic wait_busy(input logic v);
    for (int i = 0; i < 3000; i++) begin
      if (tx_busy == v) return;
      tick();
    end
    check("timeout_busy", {31'd0, tx_busy}, {31'd0, v});
  endtask

  task automatic wait_done;
    for (int i = 0; i < 3000; i++) begin
      if (frame_done) return;
      tick();
    end
    check("timeout_done", {31'd0, frame_done}, 32'd1);
  endtask

  task automatic wait_drain;
    for (int i = 0; i < 5000; i++) begin
      if (!frame_busy && !frame_busy_nc && q.size() == 0 && q_nc.size() == 0) return;
      tick();
    end
    check("timeout_drain", q.size() + q_nc.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_start"}, {31'd0, tx_start}, 32'd0);
    check({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
    check({tag, "_frame_busy"}, {31'd0, frame_busy}, 32'd0);
    check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    check({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    check({tag, "_frame_count"}, {16'd0, frame_count}, 32'd0);
  endtask

  logic [7:0] basic9[9] = '{8'h61, 8'h62, 8'h91, 8'h01, 8'h34, 8'h12, 8'hD8, 8'h0D, 8'h0A};
  logic [7:0] basic8[8] = '{8'h61, 8'h62, 8'h91, 8'h01, 8'h34, 8'h12, 8'h0D, 8'h0A};

  initial begin
    #2 rst_n = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Basic frame with checksum, including first-byte timing.
    foreach (basic9[i]) q.push_back(basic9[i]);
    n0 = n_start;
    d0 = n_done;
    send(16'h0191, 16'h1234);
    check("first_start_early", {31'd0, tx_start}, 32'd0);
    check("frame_busy_on", {31'd0, frame_busy}, 32'd1);
    tick();
    check("first_start", {31'd0, tx_start}, 32'd1);
    check("first_data", {24'd0, tx_data}, 32'h61);
    wait_drain();
    check("basic_nbytes", n_start - n0, 9);
    check("basic_ndone", n_done - d0, 1);
    check("basic_count", {16'd0, frame_count}, 32'd1);

    // Same stimulus without checksum.
    foreach (basic8[i]) q_nc.push_back(basic8[i]);
    n0 = n_start_nc;
    sample_valid_nc = 1'b1;
    temperature = 16'h0191;
    aux_data = 16'h1234;
    tick();
    sample_valid_nc = 1'b0;
    wait_drain();
    check("nc_nbytes", n_start_nc - n0, 8);
    check("nc_count", {16'd0, frame_count_nc}, 32'd1);

    // Pending buffer and overrun: S2 is overwritten by S3.
    d0 = n_done;
    push_frame(1'b1, 16'hA1B2, 16'hC3D4);
    send(16'hA1B2, 16'hC3D4);
    repeat (10) tick();
    send(16'h1111, 16'h2222);
    tick();
    check("no_overrun_s2", {31'd0, overrun}, 32'd0);
    repeat (10) tick();
    push_frame(1'b1, 16'hFE80, 16'h7F01);
    send(16'hFE80, 16'h7F01);
    tick();
    check("overrun_s3", {31'd0, overrun}, 32'd1);
    wait_done();
    tick();
    check("b2b_start", {31'd0, tx_start}, 32'd1);
    check("b2b_data", {24'd0, tx_data}, 32'h61);
    wait_drain();
    check("pend_ndone", n_done - d0, 2);
    check("pend_count", {16'd0, frame_count}, 32'd3);
    check("overrun_sticky", {31'd0, overrun}, 32'd1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("overrun_clr", {31'd0, overrun}, 32'd0);

    // Transmitter busy held for 100 cycles at frame start.
    force_busy = 1'b1;
    n0 = n_start;
    push_frame(1'b1, 16'h00FF, 16'hFF00);
    send(16'h00FF, 16'hFF00);
    repeat (100) tick();
    check("busy_hold_starts", n_start - n0, 0);
    check("busy_hold_frame_busy", {31'd0, frame_busy}, 32'd1);
    force_busy = 1'b0;
    wait_drain();
    check("busy_nbytes", n_start - n0, 9);
    check("busy_count", {16'd0, frame_count}, 32'd4);

    // sample_valid exactly on the DONE edge with pending empty.
    n0 = n_start;
    push_frame(1'b1, 16'h5A5A, 16'h0F0F);
    send(16'h5A5A, 16'h0F0F);
    wait_starts(n0 + 9);
    wait_busy(1'b1);
    wait_busy(1'b0);
    tick();
    push_frame(1'b1, 16'h8001, 16'h4002);
    sample_valid = 1'b1;
    temperature = 16'h8001;
    aux_data = 16'h4002;
    tick();
    sample_valid = 1'b0;
    check("simul_done", {31'd0, frame_done}, 32'd1);
    check("simul_count", {16'd0, frame_count}, 32'd5);
    tick();
    check("simul_start", {31'd0, tx_start}, 32'd1);
    check("simul_overrun", {31'd0, overrun}, 32'd0);
    wait_drain();
    check("simul_count2", {16'd0, frame_count}, 32'd6);
    check("simul_overrun2", {31'd0, overrun}, 32'd0);

    // Reset in the middle of a frame, after byte 3 has been accepted.
    n0 = n_start;
    push_frame(1'b1, 16'h3344, 16'h5566);
    send(16'h3344, 16'h5566);
    wait_starts(n0 + 3);
    tick();
    tick();
    rst_n = 1'b0;
    q.delete();
    #1;
    check_reset_outputs("midreset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", {31'd0, frame_busy}, 32'd0);
    n0 = n_start;
    push_frame(1'b1, 16'h0102, 16'h0304);
    send(16'h0102, 16'h0304);
    wait_drain();
    check("post_reset_nbytes", n_start - n0, 9);
    check("post_reset_count", {16'd0, frame_count}, 32'd1);

    // frame_count wrap from 16'hFFFF.
    force dut.r_frame_count = 16'hFFFF;
    tick();
    release dut.r_frame_count;
    tick();
    check("wrap_preload", {16'd0, frame_count}, 32'h0000FFFF);
    push_frame(1'b1, 16'hFFFF, 16'hFFFF);
    send(16'hFFFF, 16'hFFFF);
    wait_done();
    check("wrap_count", {16'd0, frame_count}, 32'd0);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
